// File: rtl/instruction_loader.sv
// Serial program loader: takes a LEN / big-endian word / XOR-checksum byte frame and writes
// the instruction memory, holding the CPU in reset until a frame has been loaded and verified.
module instruction_loader #(
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned INST_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [INST_BITS-1:0] wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_BITS:0]   count
);

  localparam int unsigned CntW = ADDR_BITS + 1;
  localparam int unsigned Cap  = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    StIdle, StLen, StHi, StLo, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        n_q, n_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [7:0]             acc_q, acc_d;
  logic [7:0]             hi_q, hi_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [INST_BITS-1:0]   data_q, data_d;

  logic accept;
  logic len_ok;
  logic last_word;

  assign rx_ready  = (state_q == StLen) || (state_q == StHi) ||
                     (state_q == StLo)  || (state_q == StCsum);
  assign accept    = rx_valid && rx_ready;
  assign len_ok    = (rx_data != 8'd0) && (32'(rx_data) <= Cap);
  assign last_word = (count_q + CntW'(1)) == n_q;

  assign wr_en    = (state_q == StWrite);
  assign cpu_hold = (state_q != StDone);
  assign done     = (state_q == StDone);
  assign error    = (state_q == StErr);
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign count    = count_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    count_d = count_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLen;
      end
      StLen: begin
        if (accept) begin
          n_d     = CntW'(rx_data);
          count_d = '0;
          acc_d   = '0;
          state_d = len_ok ? StHi : StErr;
        end
      end
      StHi: begin
        if (accept) begin
          hi_d    = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = StLo;
        end
      end
      StLo: begin
        if (accept) begin
          // Address/data are registered here so they hold steady after the write strobe.
          addr_d  = count_q[ADDR_BITS-1:0];
          data_d  = {hi_q, rx_data};
          acc_d   = acc_q ^ rx_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (count_q < n_q) count_d = count_q + CntW'(1);
        state_d = last_word ? StCsum : StHi;
      end
      StCsum: begin
        if (accept) state_d = (rx_data == acc_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      n_q     <= '0;
      count_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule
